// File: rtl/elixirchip_es1_spu_op_xor_reduce.sv
// Frame-wise XOR reduction with word count and fixed output latency.
// Optional m_parity output: define ELIXIRCHIP_ES1_SPU_XOR_REDUCE_PARITY_EN.
module elixirchip_es1_spu_op_xor_reduce #(
  parameter int                   LATENCY    = 2,
  parameter int                   DATA_BITS  = 8,
  parameter int                   COUNT_BITS = 16,
  parameter logic [DATA_BITS-1:0] CLEAR_DATA = '0,
  parameter                       DEVICE     = "RTL",
  parameter                       SIMULATION = "false",
  parameter                       DEBUG      = "false"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic [DATA_BITS-1:0]  s_data,
  input  logic                  s_first,
  input  logic                  s_last,
  input  logic                  s_clear,
  input  logic                  s_valid,
  output logic [DATA_BITS-1:0]  m_data,
  output logic [COUNT_BITS-1:0] m_count,
  output logic                  m_valid
`ifdef ELIXIRCHIP_ES1_SPU_XOR_REDUCE_PARITY_EN
  ,
  output logic                  m_parity
`endif
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [COUNT_BITS-1:0] CNT_ONE = COUNT_BITS'(1);

  state_t                r_state;
  state_t                w_state;
  logic [DATA_BITS-1:0]  r_acc;
  logic [DATA_BITS-1:0]  w_acc;
  logic [COUNT_BITS-1:0] r_cnt;
  logic [COUNT_BITS-1:0] w_cnt;
  logic                  w_emit;
  logic [DATA_BITS-1:0]  w_emit_data;
  logic [COUNT_BITS-1:0] w_emit_cnt;

  logic                  r_pv [LATENCY];
  logic [DATA_BITS-1:0]  r_pd [LATENCY];
  logic [COUNT_BITS-1:0] r_pc [LATENCY];

  always_comb begin
    w_state     = r_state;
    w_acc       = r_acc;
    w_cnt       = r_cnt;
    w_emit      = 1'b0;
    w_emit_data = r_acc;
    w_emit_cnt  = r_cnt;
    if (s_valid) begin
      unique case (r_state)
        IDLE: begin
          w_acc   = s_data;
          w_cnt   = CNT_ONE;
          w_state = s_last ? IDLE : ACCUM;
        end
        ACCUM: begin
          // a new first beat discards the open frame
          if (s_first) begin
            w_acc = s_data;
            w_cnt = CNT_ONE;
          end else begin
            w_acc = r_acc ^ s_data;
            w_cnt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
          end
          w_state = s_last ? IDLE : ACCUM;
        end
        default: w_state = IDLE;
      endcase
      w_emit      = s_last;
      w_emit_data = w_acc;
      w_emit_cnt  = w_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (cke && s_clear)) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= CLEAR_DATA;
        r_pc[i] <= '0;
      end
    end else if (cke) begin
      r_state <= w_state;
      r_acc   <= w_acc;
      r_cnt   <= w_cnt;
      r_pv[0] <= w_emit;
      if (w_emit) begin
        r_pd[0] <= w_emit_data;
        r_pc[0] <= w_emit_cnt;
      end
      // stages only load on a valid beat so the last stage holds its value
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) begin
          r_pd[i] <= r_pd[i-1];
          r_pc[i] <= r_pc[i-1];
        end
      end
    end
  end

  assign m_data  = r_pd[LATENCY-1];
  assign m_count = r_pc[LATENCY-1];
  assign m_valid = r_pv[LATENCY-1];

`ifdef ELIXIRCHIP_ES1_SPU_XOR_REDUCE_PARITY_EN
  logic                 r_par;
  logic                 w_fin_v;
  logic [DATA_BITS-1:0] w_fin_d;

  if (LATENCY == 1) begin : g_fin_l1
    assign w_fin_v = w_emit;
    assign w_fin_d = w_emit_data;
  end else begin : g_fin_ln
    assign w_fin_v = r_pv[LATENCY-2];
    assign w_fin_d = r_pd[LATENCY-2];
  end

  always_ff @(posedge clk) begin
    if (reset || (cke && s_clear)) begin
      r_par <= ^CLEAR_DATA;
    end else if (cke && w_fin_v) begin
      r_par <= ^w_fin_d;
    end
  end

  assign m_parity = r_par;
`endif

endmodule

// File: doc/elixirchip_es1_spu_op_xor_reduce.md
# elixirchip_es1_spu_op_xor_reduce

Frame-wise XOR reduction stage placed directly downstream of the SPU XOR op. It consumes the per-cycle `m_data` word stream from the XOR op, folds every valid word of a frame into one accumulated XOR value, and emits one result word per frame together with the frame word count. The output is delayed by a fixed, configurable pipeline latency.

## Interface
- `LATENCY`, 2: cycles from the accepted `s_last` beat to `m_valid`; must be ≥1.
- `DATA_BITS`, 8: data width.
- `COUNT_BITS`, 16: frame word counter width.
- `CLEAR_DATA`, 0: value driven on `m_data` after reset or `s_clear`.
- `DEVICE`, "RTL": target device name; passed through.
- `SIMULATION`, "false": simulation flag; passed through.
- `DEBUG`, "false": debug flag; passed through.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset; synchronous, active-high.
- `cke`  in  1: clock enable; all state holds while low.
- `s_data`  in  DATA_BITS: input word, from the XOR op output.
- `s_first`  in  1: the current beat starts a frame.
- `s_last`  in  1: the current beat ends a frame.
- `s_clear`  in  1: abort the frame and clear the outputs.
- `s_valid`  in  1: input beat valid.
- `m_data`  out  DATA_BITS: XOR of all words in the frame.
- `m_count`  out  COUNT_BITS: number of words in the frame, saturating.
- `m_valid`  out  1: single-cycle result strobe.

## Operation
- A beat is accepted when `cke & s_valid`. Nothing happens in a cycle with `cke`=0.
- State machine has two states: IDLE and ACCUM.
  - IDLE, beat accepted: `acc`=`s_data`, `cnt`=1. The beat starts a frame whether or not `s_first` is set.
    - If `s_last`=1, emit immediately and stay in IDLE.
    - Otherwise go to ACCUM.
  - ACCUM, beat without `s_first`: `acc`=`acc ^ s_data`, `cnt`=`cnt`+1.
    - `cnt` saturates at 2^COUNT_BITS−1.
    - If `s_last`=1, emit `acc ^ s_data` and go to IDLE.
  - ACCUM, beat with `s_first`: the open frame is discarded with no emit. The beat restarts the frame exactly as in IDLE.
- Emit: push {result, count} into a delay line of LATENCY stages. The result appears on `m_data`/`m_count` with `m_valid`=1 for one cycle.
- `m_data`/`m_count` hold the last emitted values while `m_valid`=0.
- `s_clear` with `cke`=1:
  - has priority over any beat in the same cycle, which is dropped;
  - sets state=IDLE, `acc`=0, `cnt`=0;
  - flushes every in-flight delay stage (valid bits cleared);
  - sets `m_data`=CLEAR_DATA, `m_count`=0.
- `s_first`/`s_last` are ignored when `s_valid`=0.

## Timing
- Reset (synchronous, active-high, independent of `cke`):
  - state=IDLE, `acc`=0, `cnt`=0;
  - all delay stages invalid;
  - `m_data`=CLEAR_DATA, `m_count`=0, `m_valid`=0.
- Latency: a `s_last` beat accepted at edge N gives `m_valid`=1 during the cycle after edge N+LATENCY−1, counting only `cke`-high edges.
- Throughput: one beat per cycle. Back-to-back single-word frames (`s_first`=`s_last`=1 every cycle) give `m_valid`=1 every cycle.
- Reset asserted mid-frame: the frame is lost and no output is produced.

## Configuration
- `ELIXIRCHIP_ES1_SPU_XOR_REDUCE_PARITY_EN` defined:
  - adds output port `m_parity`, 1 bit, which is the reduction-XOR of the emitted `m_data`;
  - `m_parity` is registered in the same final stage and aligned with `m_valid`;
  - reset/clear value is ^CLEAR_DATA.
- Undefined: the port does not exist and no parity logic is built.

## Test plan
- Reset with LATENCY=2, CLEAR_DATA=8'hA5:
  - `m_data`=A5, `m_count`=0, `m_valid`=0.
  - Then a frame 0x0F(first), 0xF0, 0x33(last) gives `m_data`=0xCC, `m_count`=3, with `m_valid` 2 cycles after the last beat.
- Single-word frames 0x01, 0x02, 0x04 on consecutive cycles -> `m_valid` high for 3 consecutive cycles carrying 01, 02, 04, each with count 1.
- Frame 0x11(first), 0x22, then 0x44(first), 0x88(last) -> exactly one result, 0xCC, count 2; the first frame is dropped.
- `cke` low for 3 cycles between beats 0xAA(first) and 0x55(last) -> result 0xFF, count 2; the output is delayed by exactly 3 cycles.
- `s_clear` with a valid `s_last` beat in the same cycle, while one result is in flight -> no `m_valid` ever; `m_data`=CLEAR_DATA, `m_count`=0.
- COUNT_BITS=2, frame of 5 words each 0x01 -> `m_data`=0x01, `m_count`=3 (saturated). With the parity macro defined, `m_parity`=1.
